// File: rtl/pack_link_sched_pkg.sv
// Shared definitions for the packet link scheduler: FSM state encodings
// and the fixed framing patterns of a 13-bit serial packet.
package pack_link_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_CMD  = 3'd2,
    ST_DAT  = 3'd3,
    ST_TAIL = 3'd4,
    ST_GAP  = 3'd5
  } state_t;

  localparam logic [3:0] HDR_PAT  = 4'b0101;
  localparam logic [3:0] TAIL_PAT = 4'b1010;
  localparam int         PKT_LEN  = 13;

endpackage

// File: rtl/pack_link_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie
// and flips to the loser whenever a grant is taken.
module rr_arb2
  import pack_link_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       valid,
  output logic       id
);

  logic ptr;

  assign valid = |req;

  always_comb begin
    id = req[1];
    if (req == 2'b11) begin
      id = ptr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (take) begin
      ptr <= ~id;
    end
  end

endmodule

// File: rtl/pack_link_sched.sv
// Packet link scheduler: grants one of two requesters and serializes a framed
// packet (header, cmd, 4 data bits MSB first, tail), then idles GAP cycles.
module pack_link_sched
  import pack_link_sched_pkg::*;
#(
  parameter int GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       cmd_0,
  input  logic       cmd_1,
  input  logic [3:0] data_0,
  input  logic [3:0] data_1,
  output logic [1:0] ack,
  output logic       gnt_id,
  output logic       busy,
  output logic       en_out,
  output logic       data_out
);

  localparam logic [3:0] GAP_LAST = 4'((GAP == 0) ? 0 : GAP - 1);

  state_t     state, state_n;
  logic [1:0] bit_cnt, bit_cnt_n;
  logic [3:0] gap_cnt, gap_cnt_n;
  logic [4:0] pkt, pkt_n;
  logic [3:0] pkt_data;
  logic       gnt_id_n;
  logic       arb_valid, arb_id, take;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .take  (take),
    .valid (arb_valid),
    .id    (arb_id)
  );

  assign busy     = (state != ST_IDLE);
  assign pkt_data = pkt[3:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      bit_cnt <= 2'd0;
      gap_cnt <= 4'd0;
      pkt     <= 5'd0;
      gnt_id  <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      gap_cnt <= gap_cnt_n;
      pkt     <= pkt_n;
      gnt_id  <= gnt_id_n;
    end
  end

  // Bits go out MSB first, so the 2-bit counter indexes each field with ~bit_cnt.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    pkt_n     = pkt;
    gnt_id_n  = gnt_id;
    take      = 1'b0;
    ack       = 2'b00;
    en_out    = 1'b0;
    data_out  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          take      = 1'b1;
          gnt_id_n  = arb_id;
          pkt_n     = arb_id ? {cmd_1, data_1} : {cmd_0, data_0};
          bit_cnt_n = 2'd0;
          state_n   = ST_HDR;
        end
      end
      ST_HDR: begin
        en_out    = 1'b1;
        data_out  = HDR_PAT[~bit_cnt];
        if (bit_cnt == 2'd0) begin
          ack[gnt_id] = 1'b1;
        end
        bit_cnt_n = bit_cnt + 2'd1;
        if (bit_cnt == 2'd3) begin
          state_n = ST_CMD;
        end
      end
      ST_CMD: begin
        en_out    = 1'b1;
        data_out  = pkt[4];
        bit_cnt_n = 2'd0;
        state_n   = ST_DAT;
      end
      ST_DAT: begin
        en_out    = 1'b1;
        data_out  = pkt_data[~bit_cnt];
        bit_cnt_n = bit_cnt + 2'd1;
        if (bit_cnt == 2'd3) begin
          state_n = ST_TAIL;
        end
      end
      ST_TAIL: begin
        en_out    = 1'b1;
        data_out  = TAIL_PAT[~bit_cnt];
        bit_cnt_n = bit_cnt + 2'd1;
        if (bit_cnt == 2'd3) begin
          gap_cnt_n = 4'd0;
          state_n   = (GAP == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        gap_cnt_n = gap_cnt + 4'd1;
        if (gap_cnt == GAP_LAST) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pack_link_sched.sv
// Bench for pack_link_sched: a schedule-level reference model checks every cycle
// of a GAP=0 and a GAP=2 instance while directed tables and sequences drive them.
module tb_pack_link_sched;
  import pack_link_sched_pkg::*;

  typedef struct {
    logic [1:0]          req;
    logic                cmd0;
    logic [3:0]          dat0;
    logic                cmd1;
    logic [3:0]          dat1;
    logic                exp_gid;
    logic [PKT_LEN-1:0]  exp_frame;
  } vec_t;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic [1:0] req    = 2'b00;
  logic       cmd_0  = 1'b0;
  logic       cmd_1  = 1'b0;
  logic [3:0] data_0 = 4'h0;
  logic [3:0] data_1 = 4'h0;
  logic [1:0] ack0, ack2;
  logic       gid0, gid2, busy0, busy2, en0, en2, do0, do2;

  int n_cmp  = 0;
  int n_fail = 0;

  int                 edge_n;
  int                 g_edge[2];
  int                 nf[2];
  int                 ptr_m[2];
  int                 gid_m[2];
  logic [PKT_LEN-1:0] frame_m[2];

  always #5 clk = ~clk;

  pack_link_sched #(.GAP(0)) dut (
    .clk(clk), .rst(rst), .req(req), .cmd_0(cmd_0), .cmd_1(cmd_1),
    .data_0(data_0), .data_1(data_1), .ack(ack0), .gnt_id(gid0),
    .busy(busy0), .en_out(en0), .data_out(do0)
  );

  pack_link_sched #(.GAP(2)) dut_g2 (
    .clk(clk), .rst(rst), .req(req), .cmd_0(cmd_0), .cmd_1(cmd_1),
    .data_0(data_0), .data_1(data_1), .ack(ack2), .gnt_id(gid2),
    .busy(busy2), .en_out(en2), .data_out(do2)
  );

  function automatic int gap_of(input int k);
    return (k == 1) ? 2 : 0;
  endfunction

  function automatic logic cur_en(input int sel);
    return (sel == 1) ? en2 : en0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    do_reset();
    req    = v.req;
    cmd_0  = v.cmd0;
    data_0 = v.dat0;
    cmd_1  = v.cmd1;
    data_1 = v.dat1;
  endtask

  // Captures the next frame on the selected instance; lows counts idle samples before it.
  task automatic wait_frame(input int sel, input logic mid_change,
                            output logic [PKT_LEN-1:0] f, output logic g, output int lows);
    int n;
    f = '0; g = 1'b0; lows = 0; n = 0;
    do begin
      tick();
      if (!cur_en(sel)) lows++;
      n++;
    end while (!cur_en(sel) && n < 200);
    checkOutput("frame_start", int'(cur_en(sel)), 1);
    if (!cur_en(sel)) return;
    g = (sel == 1) ? gid2 : gid0;
    for (int i = PKT_LEN - 1; i >= 0; i--) begin
      if (i != PKT_LEN - 1) tick();
      f[i] = (sel == 1) ? do2 : do0;
      if (mid_change && i == 6) begin
        req    = 2'b10;
        cmd_0  = ~cmd_0;
        data_0 = ~data_0;
      end
    end
  endtask

  // Reference model: a grant may happen at an edge no earlier than 14+GAP edges
  // after the previous one; the frame then occupies the 13 following samples.
  initial begin
    edge_n = 0;
    for (int k = 0; k < 2; k++) begin
      g_edge[k] = -1000; nf[k] = 0; ptr_m[k] = 0; gid_m[k] = 0; frame_m[k] = '0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst) begin
          g_edge[k] = -1000; nf[k] = edge_n + 1; ptr_m[k] = 0; gid_m[k] = 0;
        end else if (edge_n >= nf[k] && req != 2'b00) begin
          gid_m[k]   = (req == 2'b11) ? ptr_m[k] : ((req == 2'b10) ? 1 : 0);
          ptr_m[k]   = 1 - gid_m[k];
          frame_m[k] = (gid_m[k] == 1) ? {4'b0101, cmd_1, data_1, 4'b1010}
                                       : {4'b0101, cmd_0, data_0, 4'b1010};
          g_edge[k]  = edge_n;
          nf[k]      = edge_n + PKT_LEN + 1 + gap_of(k);
        end
      end
      edge_n++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        int dd;
        logic e, b, bz;
        logic [1:0] a;
        logic [5:0] expv, actv;
        dd   = (edge_n - 1) - g_edge[k];
        e    = (dd >= 0 && dd < PKT_LEN);
        b    = e ? frame_m[k][PKT_LEN - 1 - dd] : 1'b0;
        a    = (dd == 0) ? ((gid_m[k] == 1) ? 2'b10 : 2'b01) : 2'b00;
        bz   = (dd >= 0 && dd <= PKT_LEN - 1 + gap_of(k));
        expv = {a, (gid_m[k] == 1), bz, e, b};
        actv = (k == 1) ? {ack2, gid2, busy2, en2, do2} : {ack0, gid0, busy0, en0, do0};
        checkOutput((k == 1) ? "cycle_gap2" : "cycle_gap0", int'(actv), int'(expv));
      end
    end
  end

  initial begin
    vec_t vecs[5];
    logic [PKT_LEN-1:0] f;
    logic g;
    int lows;
    int cnt;

    vecs[0] = '{2'b01, 1'b1, 4'hA, 1'b0, 4'h0, 1'b0, 13'b0101_1_1010_1010};
    vecs[1] = '{2'b10, 1'b1, 4'hF, 1'b0, 4'h5, 1'b1, 13'b0101_0_0101_1010};
    vecs[2] = '{2'b11, 1'b0, 4'h3, 1'b1, 4'hC, 1'b0, 13'b0101_0_0011_1010};
    vecs[3] = '{2'b01, 1'b0, 4'hF, 1'b1, 4'h9, 1'b0, 13'b0101_0_1111_1010};
    vecs[4] = '{2'b10, 1'b0, 4'h2, 1'b1, 4'h0, 1'b1, 13'b0101_1_0000_1010};

    tick();
    tick();
    checkOutput("reset_outputs", int'({ack0, gid0, busy0, en0, do0}), 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      wait_frame(0, 1'b0, f, g, lows);
      req = 2'b00;
      checkOutput($sformatf("vec%0d_frame", i), int'(f), int'(vecs[i].exp_frame));
      checkOutput($sformatf("vec%0d_gid", i), int'(g), int'(vecs[i].exp_gid));
      checkOutput($sformatf("vec%0d_latency", i), lows, 0);
    end

    // Simultaneous requests straight out of reset: requester 0 first, then 1.
    do_reset();
    req = 2'b11; cmd_0 = 1'b1; data_0 = 4'h1; cmd_1 = 1'b0; data_1 = 4'hE;
    wait_frame(0, 1'b0, f, g, lows);
    checkOutput("rr_first_gid", int'(g), 0);
    checkOutput("rr_first_frame", int'(f), int'(13'b0101_1_0001_1010));
    wait_frame(0, 1'b0, f, g, lows);
    req = 2'b00;
    checkOutput("rr_second_gid", int'(g), 1);
    checkOutput("rr_second_frame", int'(f), int'(13'b0101_0_1110_1010));
    checkOutput("rr_idle_between", lows, 1);

    // Loopback decode of a single frame into its receiver fields.
    do_reset();
    req = 2'b01; cmd_0 = 1'b1; data_0 = 4'h6;
    wait_frame(0, 1'b0, f, g, lows);
    req = 2'b00;
    checkOutput("rx_header", int'(f[12:9]), 4'b0101);
    checkOutput("rx_cmd", int'(f[8]), 1);
    checkOutput("rx_data", int'(f[7:4]), 4'h6);
    checkOutput("rx_tail", int'(f[3:0]), 4'b1010);

    // Reset landing in the middle of the data field.
    do_reset();
    req = 2'b01; cmd_0 = 1'b0; data_0 = 4'h9; cnt = 0;
    for (int n = 0; n < 50 && cnt < 6; n++) begin
      tick();
      if (en0) cnt++;
    end
    checkOutput("mid_dat_reached", cnt, 6);
    rst = 1'b0;
    #1;
    checkOutput("rst_en_out", int'(en0), 0);
    checkOutput("rst_busy", int'(busy0), 0);
    checkOutput("rst_data_out", int'(do0), 0);
    cmd_0 = 1'b1; data_0 = 4'h3;
    tick();
    rst = 1'b1;
    wait_frame(0, 1'b0, f, g, lows);
    req = 2'b00;
    checkOutput("after_rst_latency", lows, 0);
    checkOutput("after_rst_frame", int'(f), int'(13'b0101_1_0011_1010));

    // GAP=2 instance with a held request: three quiet samples between frames.
    do_reset();
    req = 2'b01; cmd_0 = 1'b0; data_0 = 4'h5;
    wait_frame(1, 1'b0, f, g, lows);
    wait_frame(1, 1'b0, f, g, lows);
    req = 2'b00;
    checkOutput("gap2_low_run", lows, 3);
    checkOutput("gap2_frame", int'(f), int'(13'b0101_0_0101_1010));

    // Request from requester 1 raised mid-packet while requester 0's inputs change.
    do_reset();
    req = 2'b01; cmd_0 = 1'b1; data_0 = 4'hC; cmd_1 = 1'b0; data_1 = 4'h7;
    wait_frame(0, 1'b1, f, g, lows);
    checkOutput("busy_req_first_frame", int'(f), int'(13'b0101_1_1100_1010));
    checkOutput("busy_req_first_gid", int'(g), 0);
    wait_frame(0, 1'b0, f, g, lows);
    req = 2'b00;
    checkOutput("busy_req_second_gid", int'(g), 1);
    checkOutput("busy_req_second_frame", int'(f), int'(13'b0101_0_0111_1010));
    checkOutput("busy_req_wait", lows, 1);

    // Randomized traffic including occasional asynchronous resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
      cmd_0  = 1'($urandom);
      cmd_1  = 1'($urandom);
      data_0 = 4'($urandom);
      data_1 = 4'($urandom);
    end
    rst = 1'b1;
    req = 2'b00;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
